store_buffer: RTL
=================

// Module: store_buffer
// PURPOSE
//   Posted-write buffer between the CPU load/store path and DataMemory (single port, async read, posedge write).
//   CPU stores are queued and retire immediately; the queue drains to memory in idle or store-only cycles.
//   Loads get the memory port first and are forwarded from the youngest matching queued store, so the CPU always sees program order.
//   Word-granular only. Word index = address[13:2], the same 14-bit window DataMemory decodes.
// PARAMETERS
//   DEPTH   4   queue entries; power of two, 2..16
//   AW      14  address bits compared and passed to memory (address[AW-1:0])
// PORTS
//   clk            in   1   system clock, all state on posedge
//   rst_n          in   1   asynchronous active-low reset
//   cpu_address    in   32  load/store byte address, word aligned
//   cpu_dataIn     in   32  store data
//   cpu_writeEnable in  1   store request this cycle
//   cpu_readEnable in   1   load request this cycle
//   cpu_dataOut    out  32  load data, combinational, valid in the same cycle as cpu_readEnable
//   stall          out  1   store cannot be accepted; CPU holds its instruction
//   empty          out  1   no pending stores (used before halt/dump)
//   mem_address    out  32  to DataMemory address
//   mem_dataIn     out  32  to DataMemory dataIn
//   mem_writeEnable out 1   to DataMemory writeEnable
//   mem_dataOut    in   32  from DataMemory dataOut
// BEHAVIOUR
//   State: DEPTH x {addr[AW-1:2], data[31:0]}, head ptr, tail ptr, count[$clog2(DEPTH):0]; circular, pointers wrap modulo DEPTH.
//   Reset (async): head=tail=count=0; stall=0, empty=1, mem_writeEnable=0.
//     Entry contents are not cleared. Pending stores are discarded when reset is asserted mid-drain.
//   stall = full (count==DEPTH) & cpu_writeEnable. This is combinational. Stall is not lifted in a cycle that also pops.
//   Enqueue at posedge when cpu_writeEnable & ~full: entry[tail] <= {cpu_address[AW-1:2], cpu_dataIn}; tail++.
//   Port arbitration, per cycle:
//     cpu_readEnable=1: mem_address=cpu_address, mem_writeEnable=0, no drain.
//     else if count!=0: mem_address={18'b0, entry[head].addr, 2'b00}, mem_dataIn=entry[head].data, mem_writeEnable=1.
//       Pop at posedge (head++).
//     else: mem_writeEnable=0, mem_address=cpu_address.
//   Load data: the youngest valid entry whose addr equals cpu_address[AW-1:2] supplies cpu_dataOut; otherwise mem_dataOut.
//   A store in the same cycle as a load to the same word is NOT forwarded. The old value is returned, matching memory read-before-write.
//   Simultaneous push and pop: count unchanged, both pointers advance.
//   Push to full is refused. Pop from empty is impossible.
//   cpu_writeEnable & cpu_readEnable together is legal. The read wins the port; the store enqueues normally.
//   Latency: a store is visible to loads the cycle after acceptance via forwarding.
//     It reaches memory at the earliest the cycle after acceptance, and only in a cycle with no load.
//   empty = (count==0). It is registered-state derived with no combinational path from the CPU inputs.
// STRUCTURE
//   Shared package/header: WORD_LSB=2, DMEM_AW=14, and the word-index width define, shared with DataMemory and the CPU.
//   Sub-module store_buffer_match: combinational youngest-first compare over DEPTH entries.
//     Inputs: entries, valid mask, age order from head. Outputs: hit and data.
//   The top level holds the pointers, count, arbitration and output muxing.
// TESTING
//   The bench instantiates store_buffer + DataMemory. Memory is preloaded to zero.
//   The bench runs reset between scenarios and drives rst_n low for 1 cycle at start.
//   1. Store 0x0000_0010<-0xDEADBEEF, then 3 idle cycles.
//      mem_writeEnable pulses 1 cycle, memory word 4 = 0xDEADBEEF, empty=1.
//   2. 4 back-to-back stores (addr 0x0,0x4,0x8,0xC; data 1..4) with a load on every following cycle.
//      stall=0 throughout. A 5th store asserts stall=1.
//      Drain begins when loads stop, and memory ends with 1,2,3,4.
//   3. Store 0x20<-0xA, then store 0x20<-0xB, then load 0x20 in the next cycle with no drain yet.
//      cpu_dataOut=0xB (youngest forward).
//   4. Same-cycle store 0x30<-0x5 and load 0x30 with memory word 0x30 = 0x0.
//      cpu_dataOut=0x0. The next-cycle load returns 0x5.
//   5. Fill the buffer with 3 stores, then assert rst_n low mid-drain.
//      Outputs immediately go to stall=0, empty=1, mem_writeEnable=0. Undrained words stay 0 in memory.
//   6. Pointer wrap: 10 stores interleaved with idles to distinct addresses 0x100..0x124, data 0x100+i.
//      All 10 land in memory in order, and count never exceeds DEPTH.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared constants for the data-memory word window and the store buffer's memory request.
package store_buffer_pkg;
    localparam int WORD_LSB = 2;
    localparam int DMEM_AW  = 14;
    localparam int WIDX_W   = DMEM_AW - WORD_LSB;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
    } mem_req_t;
endpackage

// File: rtl/store_buffer_match.sv
// Combinational youngest-first address match over the queued store entries.
module store_buffer_match #(
    parameter int DEPTH = 4,
    parameter int IW    = 12,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic [IW-1:0]             key,
    input  logic [DEPTH-1:0][IW-1:0]  ent_addr,
    input  logic [DEPTH-1:0][31:0]    ent_data,
    input  logic [DEPTH-1:0]          valid,
    input  logic [PW-1:0]             head,
    output logic                      hit,
    output logic [31:0]               data
);
    logic [DEPTH-1:0] eq;
    logic [PW-1:0]    idx;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign eq[i] = valid[i] && (ent_addr[i] == key);
    end

    // Walk oldest to youngest so the last hit taken is the youngest store.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (eq[idx]) begin
                hit  = 1'b1;
                data = ent_data[idx];
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// Posted-write queue in front of single-port DataMemory; loads win the port and see queued stores.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = DMEM_AW
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_dataIn,
    input  logic        cpu_writeEnable,
    input  logic        cpu_readEnable,
    output logic [31:0] cpu_dataOut,
    output logic        stall,
    output logic        empty,
    output logic [31:0] mem_address,
    output logic [31:0] mem_dataIn,
    output logic        mem_writeEnable,
    input  logic [31:0] mem_dataOut
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = AW - WORD_LSB;

    logic [DEPTH-1:0][IW-1:0] ent_addr;
    logic [DEPTH-1:0][31:0]   ent_data;
    logic [DEPTH-1:0]         valid;
    logic [PW-1:0]            head, tail;
    logic [CW-1:0]            count;
    logic                     full, push, pop;
    logic                     fwd_hit;
    logic [31:0]              fwd_data;
    mem_req_t                 req;

    assign full  = (count == CW'(DEPTH));
    assign push  = cpu_writeEnable && !full;
    assign pop   = req.we;
    assign stall = full && cpu_writeEnable;
    assign empty = (count == '0);

    // Entry i is live when its distance from head is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_valid
        assign valid[i] = {1'b0, PW'(i) - head} < count;
    end

    // Contents are deliberately left unreset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= cpu_address[AW-1:WORD_LSB];
            ent_data[tail] <= cpu_dataIn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Loads own the port; the queue drains only in cycles without one.
    always_comb begin
        req.addr = cpu_address;
        req.data = ent_data[head];
        req.we   = 1'b0;
        if (!cpu_readEnable && !empty) begin
            req.addr = {{(32-AW){1'b0}}, ent_addr[head], {WORD_LSB{1'b0}}};
            req.we   = 1'b1;
        end
    end

    assign mem_address     = req.addr;
    assign mem_dataIn      = req.data;
    assign mem_writeEnable = req.we;

    store_buffer_match #(
        .DEPTH (DEPTH),
        .IW    (IW),
        .PW    (PW)
    ) u_match (
        .key      (cpu_address[AW-1:WORD_LSB]),
        .ent_addr (ent_addr),
        .ent_data (ent_data),
        .valid    (valid),
        .head     (head),
        .hit      (fwd_hit),
        .data     (fwd_data)
    );

    assign cpu_dataOut = fwd_hit ? fwd_data : mem_dataOut;
endmodule
